// File: rtl/cp0_regfile.sv
// cp0_regfile
// System-control coprocessor (CP0) register file. This is the sink of the
// exception unit's commit interface. It holds BadVAddr, Count, EntryHi,
// Compare, Status, Cause, EPC, PRId and EBase.
//
// Each cycle it commits one of three things, with exception first, then eret,
// then mtc0. An mtc0 that lands in the same cycle as an exception or an eret
// is dropped entirely. The Count timer and the sampling of the hardware
// interrupt lines run on every cycle, whatever else is committed.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cp0_raddr/rsel/rdata      mfc0 read port (combinational, no write bypass)
//   cp0_wen/waddr/wsel/wdata  mtc0 write port
//   cp0_exp_*                 exception / eret commit from the exception unit
//   hw_int                    level-sensitive external interrupt lines
//   epc_address ... timer_int state fed back to exception unit, fetch and memory
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE  = 32'h0001_8000,
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  cp0_raddr,
  input  logic [2:0]  cp0_rsel,
  output logic [31:0] cp0_rdata,
  input  logic        cp0_wen,
  input  logic [4:0]  cp0_waddr,
  input  logic [2:0]  cp0_wsel,
  input  logic [31:0] cp0_wdata,
  input  logic        cp0_exp_en,
  input  logic        cp0_exl_clean,
  input  logic [31:0] cp0_exp_epc,
  input  logic [4:0]  cp0_exp_code,
  input  logic        cp0_exp_bd,
  input  logic [31:0] cp0_exp_bad_vaddr,
  input  logic        cp0_exp_bad_vaddr_wen,
  input  logic [7:0]  cp0_exp_asid,
  input  logic        cp0_exp_asid_en,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc_address,
  output logic        allow_interrupt,
  output logic [7:0]  interrupt_flag,
  output logic [31:0] cp0_ebase,
  output logic        cp0_use_special_iv,
  output logic        cp0_use_bootstrap_iv,
  output logic        exl_set,
  output logic [7:0]  asid,
  output logic        timer_int
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_ENTRYHI  = 5'd10;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // Register state
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic        count_tog;
  logic [31:0] compare;
  logic [18:0] entryhi_vpn2;
  logic [7:0]  entryhi_asid;
  logic        status_cu0;
  logic        status_bev;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic        cause_iv;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exccode;
  logic [31:0] epc;
  logic [17:0] ebase_base;

  // Write decode
  logic mtc0_ok;
  logic wr_count;
  logic wr_compare;
  logic wr_entryhi;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic wr_ebase;

  // An mtc0 only takes effect when no exception or eret commits this cycle.
  assign mtc0_ok    = cp0_wen & ~cp0_exp_en & ~cp0_exl_clean;
  assign wr_count   = mtc0_ok && (cp0_waddr == REG_COUNT)   && (cp0_wsel == 3'd0);
  assign wr_compare = mtc0_ok && (cp0_waddr == REG_COMPARE) && (cp0_wsel == 3'd0);
  assign wr_entryhi = mtc0_ok && (cp0_waddr == REG_ENTRYHI) && (cp0_wsel == 3'd0);
  assign wr_status  = mtc0_ok && (cp0_waddr == REG_STATUS)  && (cp0_wsel == 3'd0);
  assign wr_cause   = mtc0_ok && (cp0_waddr == REG_CAUSE)   && (cp0_wsel == 3'd0);
  assign wr_epc     = mtc0_ok && (cp0_waddr == REG_EPC)     && (cp0_wsel == 3'd0);
  assign wr_ebase   = mtc0_ok && (cp0_waddr == REG_PRID)    && (cp0_wsel == 3'd1);

  // Next Count value. Count advances on every other clock, and a write
  // reloads it. count_step marks the cycles where Count takes a new value,
  // which are the only cycles where a Compare match may raise TI.
  logic [31:0] count_next;
  logic        count_step;

  always_comb begin
    count_next = count;
    count_step = 1'b0;
    if (wr_count) begin
      count_next = cp0_wdata;
      count_step = 1'b1;
    end else if (count_tog) begin
      count_next = count + 32'd1;
      count_step = 1'b1;
    end
  end

  // Count, Compare and the timer interrupt. A Compare write clears TI, and
  // it wins over a match in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 32'd0;
      count_tog <= 1'b0;
      compare   <= 32'd0;
      cause_ti  <= 1'b0;
    end else begin
      count     <= count_next;
      count_tog <= wr_count ? 1'b0 : ~count_tog;
      if (wr_compare) begin
        compare  <= cp0_wdata;
        cause_ti <= 1'b0;
      end else if (count_step && (count_next == compare)) begin
        cause_ti <= 1'b1;
      end
    end
  end

  // Status: an exception sets EXL, an eret clears it, and otherwise mtc0
  // loads the writable fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_cu0 <= 1'b0;
      status_bev <= 1'b1;
      status_im  <= 8'd0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (cp0_exp_en) begin
      status_exl <= 1'b1;
    end else if (cp0_exl_clean) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_cu0 <= cp0_wdata[28];
      status_bev <= cp0_wdata[22];
      status_im  <= cp0_wdata[15:8];
      status_exl <= cp0_wdata[1];
      status_ie  <= cp0_wdata[0];
    end
  end

  // Cause: IP[7:2] samples the hardware lines every cycle, with the timer
  // folded into IP7. While EXL is already set, a nested exception keeps BD,
  // so BD still describes the original victim that EPC points at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_bd      <= 1'b0;
      cause_iv      <= 1'b0;
      cause_ip      <= 8'd0;
      cause_exccode <= 5'd0;
    end else begin
      cause_ip[7]   <= hw_int[5] | cause_ti;
      cause_ip[6:2] <= hw_int[4:0];
      if (cp0_exp_en) begin
        if (!status_exl) begin
          cause_bd <= cp0_exp_bd;
        end
        cause_exccode <= cp0_exp_code;
      end else if (wr_cause) begin
        cause_iv      <= cp0_wdata[23];
        cause_ip[1:0] <= cp0_wdata[9:8];
      end
    end
  end

  // EPC is only captured for the first exception while EXL is clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc <= 32'd0;
    end else if (cp0_exp_en) begin
      if (!status_exl) begin
        epc <= cp0_exp_epc;
      end
    end else if (wr_epc) begin
      epc <= cp0_wdata;
    end
  end

  // BadVAddr and EntryHi. An exception for a TLB fault loads the faulting
  // VPN2 and ASID. EntryHi[12:8] does not exist and reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr     <= 32'd0;
      entryhi_vpn2 <= 19'd0;
      entryhi_asid <= 8'd0;
    end else if (cp0_exp_en) begin
      if (cp0_exp_bad_vaddr_wen) begin
        badvaddr     <= cp0_exp_bad_vaddr;
        entryhi_vpn2 <= cp0_exp_bad_vaddr[31:13];
      end
      if (cp0_exp_asid_en) begin
        entryhi_asid <= cp0_exp_asid;
      end
    end else if (wr_entryhi) begin
      entryhi_vpn2 <= cp0_wdata[31:13];
      entryhi_asid <= cp0_wdata[7:0];
    end
  end

  // EBase: only the exception-base field [29:12] is stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ebase_base <= EBASE_RESET[29:12];
    end else if (wr_ebase) begin
      ebase_base <= cp0_wdata[29:12];
    end
  end

  // Architectural views of the packed registers
  logic [31:0] status_word;
  logic [31:0] cause_word;
  logic [31:0] entryhi_word;
  logic [31:0] ebase_word;

  assign status_word  = {3'b000, status_cu0, 5'b00000, status_bev, 6'b000000,
                         status_im, 6'b000000, status_exl, status_ie};
  assign cause_word   = {cause_bd, cause_ti, 6'b000000, cause_iv, 7'b0000000,
                         cause_ip, 1'b0, cause_exccode, 2'b00};
  assign entryhi_word = {entryhi_vpn2, 5'b00000, entryhi_asid};
  assign ebase_word   = {2'b10, ebase_base, 12'h000};

  // mfc0 read mux. Any register/select pair not listed here reads zero.
  always_comb begin
    cp0_rdata = 32'd0;
    case ({cp0_raddr, cp0_rsel})
      {REG_BADVADDR, 3'd0}: cp0_rdata = badvaddr;
      {REG_COUNT,    3'd0}: cp0_rdata = count;
      {REG_ENTRYHI,  3'd0}: cp0_rdata = entryhi_word;
      {REG_COMPARE,  3'd0}: cp0_rdata = compare;
      {REG_STATUS,   3'd0}: cp0_rdata = status_word;
      {REG_CAUSE,    3'd0}: cp0_rdata = cause_word;
      {REG_EPC,      3'd0}: cp0_rdata = epc;
      {REG_PRID,     3'd0}: cp0_rdata = PRID_VALUE;
      {REG_PRID,     3'd1}: cp0_rdata = ebase_word;
      default:              cp0_rdata = 32'd0;
    endcase
  end

  assign epc_address          = epc;
  assign allow_interrupt      = status_ie & ~status_exl;
  assign interrupt_flag       = cause_ip & status_im;
  assign cp0_ebase            = ebase_word;
  assign cp0_use_special_iv   = cause_iv;
  assign cp0_use_bootstrap_iv = status_bev;
  assign exl_set              = status_exl;
  assign asid                 = entryhi_asid;
  assign timer_int            = cause_ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile
// Directed bench for cp0_regfile. Every expected value below is a
// hand-computed constant taken from the register field layout.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cp0_raddr;
  logic [2:0]  cp0_rsel;
  logic [31:0] cp0_rdata;
  logic        cp0_wen;
  logic [4:0]  cp0_waddr;
  logic [2:0]  cp0_wsel;
  logic [31:0] cp0_wdata;
  logic        cp0_exp_en;
  logic        cp0_exl_clean;
  logic [31:0] cp0_exp_epc;
  logic [4:0]  cp0_exp_code;
  logic        cp0_exp_bd;
  logic [31:0] cp0_exp_bad_vaddr;
  logic        cp0_exp_bad_vaddr_wen;
  logic [7:0]  cp0_exp_asid;
  logic        cp0_exp_asid_en;
  logic [5:0]  hw_int;
  logic [31:0] epc_address;
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;
  logic [31:0] cp0_ebase;
  logic        cp0_use_special_iv;
  logic        cp0_use_bootstrap_iv;
  logic        exl_set;
  logic [7:0]  asid;
  logic        timer_int;

  int vec_count  = 0;
  int miss_count = 0;

  cp0_regfile dut (
    .clk                  (clk),
    .rst                  (rst),
    .cp0_raddr            (cp0_raddr),
    .cp0_rsel             (cp0_rsel),
    .cp0_rdata            (cp0_rdata),
    .cp0_wen              (cp0_wen),
    .cp0_waddr            (cp0_waddr),
    .cp0_wsel             (cp0_wsel),
    .cp0_wdata            (cp0_wdata),
    .cp0_exp_en           (cp0_exp_en),
    .cp0_exl_clean        (cp0_exl_clean),
    .cp0_exp_epc          (cp0_exp_epc),
    .cp0_exp_code         (cp0_exp_code),
    .cp0_exp_bd           (cp0_exp_bd),
    .cp0_exp_bad_vaddr    (cp0_exp_bad_vaddr),
    .cp0_exp_bad_vaddr_wen(cp0_exp_bad_vaddr_wen),
    .cp0_exp_asid         (cp0_exp_asid),
    .cp0_exp_asid_en      (cp0_exp_asid_en),
    .hw_int               (hw_int),
    .epc_address          (epc_address),
    .allow_interrupt      (allow_interrupt),
    .interrupt_flag       (interrupt_flag),
    .cp0_ebase            (cp0_ebase),
    .cp0_use_special_iv   (cp0_use_special_iv),
    .cp0_use_bootstrap_iv (cp0_use_bootstrap_iv),
    .exl_set              (exl_set),
    .asid                 (asid),
    .timer_int            (timer_int)
  );

  // 10-unit clock; stimulus changes on the falling edge.
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check, reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_count++;
    if (got !== want) begin
      miss_count++;
      $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, want);
    end
  endtask

  // One mtc0 write, held across exactly one rising edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [2:0] sel, input logic [31:0] data);
    @(negedge clk);
    cp0_wen   = 1'b1;
    cp0_waddr = addr;
    cp0_wsel  = sel;
    cp0_wdata = data;
    @(negedge clk);
    cp0_wen   = 1'b0;
  endtask

  // One exception commit; optionally carries a colliding mtc0 EPC write.
  task automatic applyException(input logic [31:0] epc, input logic [4:0] code, input logic bd,
                                input logic [31:0] bva, input logic bva_wen,
                                input logic [7:0] asid_in, input logic asid_wen,
                                input logic with_mtc0);
    @(negedge clk);
    cp0_exp_en            = 1'b1;
    cp0_exp_epc           = epc;
    cp0_exp_code          = code;
    cp0_exp_bd            = bd;
    cp0_exp_bad_vaddr     = bva;
    cp0_exp_bad_vaddr_wen = bva_wen;
    cp0_exp_asid          = asid_in;
    cp0_exp_asid_en       = asid_wen;
    if (with_mtc0) begin
      cp0_wen   = 1'b1;
      cp0_waddr = 5'd14;
      cp0_wsel  = 3'd0;
      cp0_wdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    cp0_exp_en            = 1'b0;
    cp0_exp_bad_vaddr_wen = 1'b0;
    cp0_exp_asid_en       = 1'b0;
    cp0_wen               = 1'b0;
  endtask

  task automatic applyEret();
    @(negedge clk);
    cp0_exl_clean = 1'b1;
    @(negedge clk);
    cp0_exl_clean = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] addr, input logic [2:0] sel, output logic [31:0] data);
    cp0_raddr = addr;
    cp0_rsel  = sel;
    #1;
    data = cp0_rdata;
  endtask

  // Main directed sequence
  initial begin
    logic [31:0] rd;
    int          rise_cycle;

    rst = 1'b1;
    cp0_raddr = '0; cp0_rsel = '0;
    cp0_wen = 1'b0; cp0_waddr = '0; cp0_wsel = '0; cp0_wdata = '0;
    cp0_exp_en = 1'b0; cp0_exl_clean = 1'b0; cp0_exp_epc = '0; cp0_exp_code = '0;
    cp0_exp_bd = 1'b0; cp0_exp_bad_vaddr = '0; cp0_exp_bad_vaddr_wen = 1'b0;
    cp0_exp_asid = '0; cp0_exp_asid_en = 1'b0; hw_int = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    readReg(5'd12, 3'd0, rd); checkOutput("reset_status", rd, 32'h0040_0000);
    readReg(5'd15, 3'd1, rd); checkOutput("reset_ebase", rd, 32'h8000_0000);
    readReg(5'd15, 3'd0, rd); checkOutput("reset_prid", rd, 32'h0001_8000);
    readReg(5'd13, 3'd0, rd); checkOutput("reset_cause", rd, 32'h0000_0000);
    checkOutput("reset_bev_out", {31'd0, cp0_use_bootstrap_iv}, 32'd1);
    checkOutput("reset_ebase_out", cp0_ebase, 32'h8000_0000);
    checkOutput("reset_epc_out", epc_address, 32'd0);
    checkOutput("reset_allow", {31'd0, allow_interrupt}, 32'd0);
    checkOutput("reset_exl", {31'd0, exl_set}, 32'd0);

    // Unimplemented register/select pairs
    readReg(5'd0, 3'd0, rd);  checkOutput("unimpl_r0", rd, 32'd0);
    readReg(5'd15, 3'd2, rd); checkOutput("unimpl_r15s2", rd, 32'd0);
    readReg(5'd12, 3'd1, rd); checkOutput("unimpl_r12s1", rd, 32'd0);

    // Writable-field masks
    applyStimulus(5'd12, 3'd0, 32'hFFFF_FFFF);
    readReg(5'd12, 3'd0, rd); checkOutput("status_mask", rd, 32'h1040_FF03);
    checkOutput("allow_exl_set", {31'd0, allow_interrupt}, 32'd0);
    checkOutput("exl_from_mtc0", {31'd0, exl_set}, 32'd1);
    applyStimulus(5'd15, 3'd1, 32'hFFFF_FFFF);
    readReg(5'd15, 3'd1, rd); checkOutput("ebase_mask", rd, 32'hBFFF_F000);
    checkOutput("ebase_out", cp0_ebase, 32'hBFFF_F000);
    applyStimulus(5'd12, 3'd0, 32'h0000_0001);
    checkOutput("allow_ie", {31'd0, allow_interrupt}, 32'd1);
    checkOutput("bev_cleared", {31'd0, cp0_use_bootstrap_iv}, 32'd0);

    // First exception with EXL clear, then a nested one, then eret
    applyException(32'hBFC0_0100, 5'h0C, 1'b1, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    readReg(5'd14, 3'd0, rd); checkOutput("exc1_epc", rd, 32'hBFC0_0100);
    checkOutput("exc1_epc_out", epc_address, 32'hBFC0_0100);
    readReg(5'd13, 3'd0, rd); checkOutput("exc1_cause", rd, 32'h8000_0030);
    checkOutput("exc1_exl", {31'd0, exl_set}, 32'd1);
    checkOutput("exc1_allow", {31'd0, allow_interrupt}, 32'd0);
    applyException(32'h0000_1234, 5'h04, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    readReg(5'd14, 3'd0, rd); checkOutput("exc2_epc_held", rd, 32'hBFC0_0100);
    readReg(5'd13, 3'd0, rd); checkOutput("exc2_cause", rd, 32'h8000_0010);
    applyEret();
    checkOutput("eret_exl", {31'd0, exl_set}, 32'd0);
    readReg(5'd14, 3'd0, rd); checkOutput("eret_epc", rd, 32'hBFC0_0100);

    // TLB-style exception with a colliding mtc0 EPC that must be dropped
    applyException(32'h0040_0010, 5'h02, 1'b0, 32'h0040_2ABC, 1'b1, 8'h5A, 1'b1, 1'b1);
    readReg(5'd8, 3'd0, rd);  checkOutput("tlb_badvaddr", rd, 32'h0040_2ABC);
    readReg(5'd10, 3'd0, rd); checkOutput("tlb_entryhi", rd, 32'h0040_205A);
    checkOutput("tlb_asid_out", {24'd0, asid}, 32'h0000_005A);
    readReg(5'd14, 3'd0, rd); checkOutput("tlb_epc_no_mtc0", rd, 32'h0040_0010);
    applyEret();

    // Timer: park Count away from Compare, then arm Compare=10, Count=0
    applyStimulus(5'd12, 3'd0, 32'h0000_8001);
    applyStimulus(5'd9, 3'd0, 32'h0000_1000);
    readReg(5'd9, 3'd0, rd); checkOutput("count_load", rd, 32'h0000_1000);
    applyStimulus(5'd11, 3'd0, 32'd10);
    readReg(5'd11, 3'd0, rd); checkOutput("compare_load", rd, 32'd10);
    applyStimulus(5'd9, 3'd0, 32'd0);
    checkOutput("timer_idle", {31'd0, timer_int}, 32'd0);
    rise_cycle = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (timer_int) begin
        rise_cycle = i;
        break;
      end
    end
    checkOutput("timer_window", {31'd0, (rise_cycle >= 19 && rise_cycle <= 21)}, 32'd1);
    readReg(5'd9, 3'd0, rd); checkOutput("count_at_match", rd, 32'd10);
    @(posedge clk); #1;
    checkOutput("ip7_flag", {24'd0, interrupt_flag}, 32'h0000_0080);
    applyStimulus(5'd12, 3'd0, 32'h0000_0001);
    checkOutput("ip7_masked", {24'd0, interrupt_flag}, 32'd0);
    readReg(5'd13, 3'd0, rd); checkOutput("cause_ti_ip7", rd, 32'h4000_8008);
    applyStimulus(5'd11, 3'd0, 32'hFFFF_0000);
    checkOutput("timer_cleared", {31'd0, timer_int}, 32'd0);
    @(posedge clk); #1;
    readReg(5'd13, 3'd0, rd); checkOutput("ip7_dropped", rd, 32'h0000_0008);

    // Hardware interrupt line 0 through IM2, then Cause IV/IP[1:0]
    applyStimulus(5'd12, 3'd0, 32'h0000_0401);
    @(negedge clk);
    hw_int = 6'b000001;
    #1;
    checkOutput("hwint_not_yet", {24'd0, interrupt_flag}, 32'd0);
    @(posedge clk); #1;
    checkOutput("hwint_flag", {24'd0, interrupt_flag}, 32'h0000_0004);
    applyStimulus(5'd13, 3'd0, 32'hFFFF_FFFF);
    readReg(5'd13, 3'd0, rd); checkOutput("cause_mask", rd, 32'h0080_0708);
    checkOutput("special_iv", {31'd0, cp0_use_special_iv}, 32'd1);

    // Asynchronous reset in the middle of a clock phase
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_epc", epc_address, 32'd0);
    checkOutput("async_allow", {31'd0, allow_interrupt}, 32'd0);
    checkOutput("async_flag", {24'd0, interrupt_flag}, 32'd0);
    checkOutput("async_ebase", cp0_ebase, 32'h8000_0000);
    checkOutput("async_bev", {31'd0, cp0_use_bootstrap_iv}, 32'd1);
    checkOutput("async_iv", {31'd0, cp0_use_special_iv}, 32'd0);
    checkOutput("async_asid", {24'd0, asid}, 32'd0);
    readReg(5'd12, 3'd0, rd); checkOutput("async_status", rd, 32'h0040_0000);
    hw_int = '0;
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
